mulseq: RTL and testbench
=========================

# mulseq

Iterative radix-2^R integer multiplier for the MDU. It is the area-optimised sibling of the pipelined partial-product multiplier, for small cores. One multiply is accepted per Start handshake. The multiplier digests R bits of the multiplier operand per cycle and returns the RISC-V M-extension result (MUL/MULH/MULHSU/MULHU, plus MULW when XLEN=64). It sits in the Execute stage beside the divider and shares its Start/Busy/Done protocol with the hazard unit.

## Interface
- XLEN, 64: operand/result width; 32 or 64.
- RBITS, 2: multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide 32.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- FlushE  in  1  abort in-flight operation.
- StartE  in  1  request; sampled only when idle-capable (see Operation).
- Funct3E  in  3  000 MUL low, 001 MULH s×s high, 010 MULHSU s×u high, 011 MULHU u×u high; 1xx illegal (treated as 000).
- WE  in  1  word op (MULW); ignored when XLEN=32.
- ForwardedSrcAE  in  XLEN  multiplicand A.
- ForwardedSrcBE  in  XLEN  multiplier B.
- BusyE  out  1  operation in progress; Start not accepted.
- DoneE  out  1  one-cycle pulse; ResultE valid.
- ResultE  out  XLEN  selected result; held until next accepted Start completes.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE; BusyE=0, DoneE=0, ResultE=0, iteration counter=0, accumulators=0.
- Accept: StartE=1 in IDLE or DONE with FlushE=0. Operands, Funct3E and WE are latched. Next state is BUSY with counter=N-1. Inputs are not required stable after acceptance.
- N = XLEN/RBITS; for a word op (XLEN=64, WE=1), N = 32/RBITS.
- Operand extension to XLEN+1 bits: A is signed for 001 and 010; B is signed for 001 only. For a word op, A and B are the low 32 bits, sign-extended, with mode = MUL.
- Each BUSY cycle, the product register adds A×digit, where digit is the next RBITS of B, LSB first, then shifts right RBITS. The final digit of a signed B carries negative weight (subtract on the sign term). Any correct signed-digit scheme is acceptable if results are bit-exact.
- Counter decrements each BUSY cycle. BUSY with counter=0 → DONE.
- DONE: DoneE=1 for exactly one cycle. ResultE is product[XLEN-1:0] for 000. For 001/010/011 it is product[2XLEN-1:XLEN]. For a word op it is sign-extend(product[31:0]). Next state is IDLE, or BUSY if a new Start is accepted the same cycle.
- ResultE is a register: it updates only on entry to DONE and otherwise holds.
- Start while BUSY is ignored; no queueing.
- FlushE=1 in any state: next state IDLE, counter cleared, DoneE=0 next cycle, ResultE unchanged. FlushE with StartE in the same cycle: flush wins and the Start is dropped.
- reset asserted mid-operation: same as the reset values above; the aborted operation never raises DoneE.
- Arithmetic is modulo 2^(2·XLEN). No overflow flag.

## Timing
- Start accepted at edge 0: BusyE=1 in cycles 1..N; DoneE=1 and ResultE valid in cycle N+1; BusyE=0 in cycle N+1.
- Total latency N+1 cycles: XLEN=64/RBITS=2 gives 33 cycles; a word op gives 17.
- Back-to-back: Start in the DONE cycle gives BusyE=1 the following cycle. Throughput is one op per N+1 cycles.
- BusyE and DoneE are registered-state decodes with no combinational path from StartE.

## Test plan
- XLEN=32, RBITS=2: MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF, Start at cycle 0 → BusyE cycles 1–16, DoneE cycle 17, ResultE=0xFFFFFFFE.
- MULH with A=0x80000000, B=0x80000000 → 0x40000000. MULHSU with A=0xFFFFFFFF (−1), B=0x00000002 → 0xFFFFFFFF. MUL with A=7, B=−3 → 0xFFFFFFEB.
- XLEN=64, MULW with A=0x00000000_7FFFFFFF, B=2 → ResultE=0xFFFFFFFF_FFFFFFFE, DoneE in cycle 17.
- FlushE at cycle 5 of a MUL: no DoneE for 40 cycles, ResultE keeps the prior value, a Start at cycle 7 completes normally. Repeat with reset instead of FlushE: all outputs 0.
- StartE held high continuously with changing operands: the op accepted in each DONE cycle produces a result every N+1 cycles. A Start during BUSY with different operands does not alter the in-flight result.
- Random sweep over RBITS∈{1,2,4,8}, Funct3 000–011, and corner operands 0, 1, −1, MIN, MAX against a reference model: bit-exact, 10k ops per configuration.

Source files
------------

// File: rtl/mulseq.sv
// mulseq: iterative radix-2^RBITS integer multiplier for the MDU (RV M-extension).
// Retires RBITS bits of the multiplier operand per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   FlushE              abort any in-flight operation (wins over StartE)
//   StartE              request, accepted in IDLE or DONE
//   Funct3E, WE         operation select (MUL/MULH/MULHSU/MULHU, MULW when XLEN=64)
//   ForwardedSrcAE/BE   multiplicand A / multiplier B
//   BusyE, DoneE        operation in progress / one-cycle completion pulse
//   ResultE             registered result, held until the next completion
module mulseq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RBITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic            WE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  localparam int unsigned NFULL = XLEN / RBITS;
  localparam int unsigned NWORD = 32 / RBITS;
  localparam int unsigned CW    = $clog2(NFULL);
  localparam int unsigned XW    = XLEN + 1;
  // Upper accumulator: holds A (XLEN+1 signed) times a partial B scaled down, plus headroom.
  localparam int unsigned AW    = XLEN + RBITS + 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic signed [XLEN:0]  a_q;
  logic [XLEN-1:0]       b_q;
  logic [XLEN-1:0]       lo_q;
  logic signed [AW-1:0]  acc_q;
  logic                  bsgn_q;
  logic                  hi_q;
  logic                  word_q;
  logic                  busy_q;
  logic                  done_q;
  logic [XLEN-1:0]       res_q;

  // Operand decode and extension for a newly requested operation.
  logic [1:0]            mode_c;
  logic                  word_c;
  logic                  a_sgn_c;
  logic                  b_sgn_c;
  logic signed [XLEN:0]  a_ext_c;

  always_comb begin
    mode_c  = Funct3E[2] ? 2'b00 : Funct3E[1:0];
    word_c  = (XLEN == 64) && WE;
    a_sgn_c = (mode_c == 2'b01) || (mode_c == 2'b10);
    b_sgn_c = (mode_c == 2'b01);
    if (word_c) begin
      a_ext_c = XW'($signed(ForwardedSrcAE[31:0]));
    end else begin
      a_ext_c = {a_sgn_c & ForwardedSrcAE[XLEN-1], ForwardedSrcAE};
    end
  end

  // One radix step: add A*digit into the upper accumulator, shift the low RBITS out into lo.
  // The final digit of a signed B is taken as a signed RBITS-bit value (negative weight).
  logic                  last_c;
  logic signed [RBITS:0] digit_c;
  logic signed [AW-1:0]  sum_c;
  logic signed [AW-1:0]  acc_d;
  logic [XLEN-1:0]       lo_d;
  logic [XLEN-1:0]       res_d;

  always_comb begin
    last_c  = (cnt_q == '0);
    digit_c = {bsgn_q & last_c & b_q[RBITS-1], b_q[RBITS-1:0]};
    sum_c   = acc_q + AW'(a_q) * AW'(digit_c);
    acc_d   = sum_c >>> RBITS;
    lo_d    = {sum_c[RBITS-1:0], lo_q[XLEN-1:RBITS]};
    // A word op only shifts 32 bits into lo, so its product sits in the top half of lo.
    if (word_q) begin
      res_d = XLEN'($signed(lo_d[XLEN-1 -: 32]));
    end else if (hi_q) begin
      res_d = acc_d[XLEN-1:0];
    end else begin
      res_d = lo_d;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      bsgn_q  <= 1'b0;
      hi_q    <= 1'b0;
      word_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else if (FlushE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          b_q   <= b_q >> RBITS;
          if (last_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= res_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (StartE) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            a_q     <= a_ext_c;
            b_q     <= ForwardedSrcBE;
            acc_q   <= '0;
            lo_q    <= '0;
            bsgn_q  <= b_sgn_c | word_c;
            hi_q    <= (mode_c != 2'b00) && !word_c;
            word_q  <= word_c;
            cnt_q   <= word_c ? CW'(NWORD - 1) : CW'(NFULL - 1);
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign BusyE   = busy_q;
  assign DoneE   = done_q;
  assign ResultE = res_q;

endmodule

// File: tb/tb_mulseq.sv
// Scoreboard bench for mulseq (XLEN=64, RBITS=2): directed corner ops, flush/reset aborts,
// continuous Start, and a randomized sweep against a wide-arithmetic reference model.
module tb_mulseq;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RBITS = 2;
  localparam int NF = XLEN / RBITS;
  localparam int NW = 32 / RBITS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FlushE = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  Funct3E = 3'd0;
  logic        WE = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        BusyE;
  logic        DoneE;
  logic [63:0] ResultE;

  always #5 clk = ~clk;

  mulseq #(.XLEN(XLEN), .RBITS(RBITS)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StartE(StartE),
    .Funct3E(Funct3E), .WE(WE), .ForwardedSrcAE(A), .ForwardedSrcBE(B),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  typedef struct {
    logic [63:0] res;
    int          done;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          free_cyc = 0;
  int          rst_cyc = -1;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;
  logic [63:0] last_res = '0;

  // Reference: exact product in 128-bit arithmetic from the operand signedness rules.
  function automatic logic [63:0] ref_mul(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ax, bx, p;
    logic [1:0]   m;
    if (w) begin
      ax = {{96{a[31]}}, a[31:0]};
      bx = {{96{b[31]}}, b[31:0]};
      p  = ax * bx;
      return {{32{p[31]}}, p[31:0]};
    end
    m  = f[2] ? 2'b00 : f[1:0];
    ax = (m == 2'b01 || m == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
    bx = (m == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ax * bx;
    return (m == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 8))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'h0000_0000_8000_0000;
      6: return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive one cycle of inputs, then apply the behavioural model at the sampling edge.
  task automatic step(input logic st, input logic fl, input logic rs, input logic [2:0] f,
                      input logic w, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_res);
    int n;
    StartE = st; FlushE = fl; reset = rs; Funct3E = f; WE = w; A = a; B = b;
    @(posedge clk);
    if (rs) begin
      sb.delete();
      free_cyc = cyc + 1;
      rst_cyc  = cyc + 1;
      mon_en   = 1'b1;
    end else if (fl) begin
      while (sb.size() > 0 && sb[sb.size()-1].done > cyc) void'(sb.pop_back());
      free_cyc = cyc + 1;
    end else if (st && cyc >= free_cyc) begin
      n = w ? NW : NF;
      sb.push_back('{res: exp_res, done: cyc + n + 1});
      free_cyc = cyc + n + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), {$urandom, $urandom},
         {$urandom, $urandom}, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res);
    step(1'b1, 1'b0, 1'b0, f, w, a, b, exp_res);
    repeat ((w ? NW : NF) + 1) idle();
  endtask

  task automatic rnd_step(input int p_start, input int p_flush, input int p_rst);
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b;
    int          r;
    f = 3'($urandom_range(0, 7));
    w = ($urandom_range(0, 3) == 0);
    a = pick();
    b = pick();
    r = $urandom_range(0, 999);
    step(($urandom_range(0, 99) < p_start), (r < p_flush), (r >= 999 - p_rst), f, w, a, b,
         ref_mul(f, w, a, b));
  endtask

  // Monitor: compares BusyE/DoneE/ResultE each cycle against the scoreboard.
  logic exp_busy, exp_done;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_cyc) last_res = '0;
      exp_busy = (sb.size() > 0) && (sb[0].done > cyc);
      exp_done = (sb.size() > 0) && (sb[0].done == cyc);
      if (exp_done) begin
        last_res = sb[0].res;
        void'(sb.pop_front());
      end
      checks += 3;
      if (BusyE !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BusyE, exp_busy);
      end
      if (DoneE !== exp_done) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, DoneE, exp_done);
      end
      if (ResultE !== last_res) begin
        failures++;
        $display("FAIL result cyc=%0d got=%h exp=%h", cyc, ResultE, last_res);
      end
      if (end_req && !end_done) begin
        checks++;
        if (sb.size() != 0) begin
          failures++;
          $display("FAIL drain cyc=%0d outstanding=%0d exp=0", cyc, sb.size());
        end
        end_done = 1'b1;
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, '0, '0, '0);
    repeat (3) idle();

    // Directed corner ops with hand-derived results.
    run_op(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000);
    run_op(3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b101, 1'b0, 64'd5, 64'd6, 64'd30);

    // Flush at cycle 5 of a MUL, long idle, then a fresh op.
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd3, 64'd9, 64'd27);
    repeat (4) idle();
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, '0, '0, '0);
    repeat (40) idle();
    run_op(3'b000, 1'b0, 64'd11, 64'd13, 64'd143);

    // Flush at cycle 5, Start at cycle 7.
    step(1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 64'd100, 64'd100, 64'd0);
    repeat (4) idle();
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, '0, '0, '0);
    idle();
    run_op(3'b011, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1);

    // Flush together with Start: Start dropped.
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 64'd2, 64'd2, 64'd4);
    repeat (NF + 3) idle();

    // Reset mid-operation: outputs return to zero and no DoneE.
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd5, 64'd5, 64'd25);
    repeat (5) idle();
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, '0, '0, '0);
    repeat (40) idle();

    // StartE held high with changing operands; only DONE/IDLE-cycle Starts are taken.
    for (int k = 0; k < 5 * (NF + 1) + 3; k++) rnd_step(100, 0, 0);
    repeat (NF + 3) idle();

    // Randomized sweep with occasional flush and reset.
    for (int k = 0; k < 8000; k++) rnd_step(30, 8, 2);
    repeat (NF + 3) idle();

    end_req = 1'b1;
    repeat (3) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
